// File: rtl/flit_pkg.sv
// ============================================================================
// Module : flit_pkg
// Brief  : Flit field layout and shared constants for the injection stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flit_pkg;

  localparam int FLIT_W     = 10;
  localparam int GOLDEN_BIT = 9;
  localparam int DEST_MSB   = 8;
  localparam int DEST_LSB   = 6;

  localparam logic [FLIT_W-1:0] NULL_FLIT  = '0;
  localparam logic [2:0]        DEST_LOCAL = 3'b010;

  // Everything below the golden bit; a flit with these all zero carries nothing
  localparam logic [FLIT_W-1:0] BODY_MASK  = ~(FLIT_W'(1) << GOLDEN_BIT);

endpackage

`default_nettype wire

// File: rtl/flit_fifo.sv
// ============================================================================
// Module : flit_fifo
// Brief  : Synchronous FIFO, power-of-two depth, registered full/empty/count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flit_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/flit_inject_buffer.sv
// ============================================================================
// Module : flit_inject_buffer
// Brief  : Injects buffered local flits into empty link slots ahead of the
//          deflection arbiter. Optional starvation marking: FLIT_INJECT_GOLDEN_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flit_inject_buffer
  import flit_pkg::*;
#(
  parameter int FLIT_W       = flit_pkg::FLIT_W,
  parameter int DEPTH        = 4
`ifdef FLIT_INJECT_GOLDEN_EN
  ,
  parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLIT_W-1:0]        link_in,
  output logic [FLIT_W-1:0]        link_out,
  input  logic                     inj_valid,
  input  logic [FLIT_W-1:0]        inj_flit,
  output logic                     inj_ready,
  output logic                     inj_fire,
  output logic [$clog2(DEPTH):0]   occupancy
);

  logic [FLIT_W-1:0] head;
  logic [FLIT_W-1:0] inj_word;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              link_free;
  logic              golden;

  assign link_free = (link_in == '0);
  assign push      = inj_valid && !full && ((inj_flit & BODY_MASK) != '0);
  assign pop       = link_free && !empty;
  assign inj_ready = !full;

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (inj_flit & BODY_MASK),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

`ifdef FLIT_INJECT_GOLDEN_EN
  logic [7:0] head_age;

  // Age of the current head: counts cycles it waited behind a busy link
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_age <= '0;
    end else if (empty || pop) begin
      head_age <= '0;
    end else if (head_age != 8'hFF) begin
      head_age <= head_age + 8'd1;
    end
  end

  assign golden = (head_age >= 8'(STARVE_LIMIT));
`else
  assign golden = 1'b0;
`endif

  assign inj_word = head | (FLIT_W'(golden) << GOLDEN_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_out <= '0;
      inj_fire <= 1'b0;
    end else begin
      if (!link_free) begin
        link_out <= link_in;
      end else if (pop) begin
        link_out <= inj_word;
      end else begin
        link_out <= '0;
      end
      inj_fire <= pop;
    end
  end

endmodule

`default_nettype wire
